// File: rtl/sram_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | sram_ctrl_pkg : shared types and constants for the SRAM controller   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package sram_ctrl_pkg;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  localparam int RSP_DEPTH = 2;
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

endpackage

`default_nettype wire

// File: rtl/sram_rsp_fifo.sv
// +----------------------------------------------------------------------+
// | sram_rsp_fifo : 2-entry synchronous response FIFO (head/tail regs)   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] pop_data
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_eff;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop_eff = pop && (count_q != '0);
    unique case ({push, pop_eff})
      2'b10: begin
        if (count_q == '0) head_d = push_data;
        else               tail_d = push_data;
        count_d = count_q + 1'b1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 1'b1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps the count; data shifts in order.
        if (count_q == CNT_W'(1)) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign valid    = (count_q != '0);
  assign full     = (count_q == CNT_W'(RSP_DEPTH));
  assign count    = count_q;
  assign pop_data = head_q;

endmodule

`default_nettype wire

// File: rtl/sram_access_ctrl.sv
// +----------------------------------------------------------------------+
// | sram_access_ctrl : write/read arbiter and response buffer in front   |
// |                    of a single-port SRAM (1-cycle registered Q)      |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int WIDTH         = 128,
  parameter  int NUM_ROWS      = 4096,
  localparam int ADDRESS_WIDTH = $clog2(NUM_ROWS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [WIDTH-1:0]         wr_mask,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     CEB,
  output logic                     WEB,
  output logic [ADDRESS_WIDTH-1:0] A,
  output logic [WIDTH-1:0]         D,
  output logic [WIDTH-1:0]         M,
  input  logic [WIDTH-1:0]         Q
);

  localparam logic [ADDRESS_WIDTH:0] ROWS_LIMIT = (ADDRESS_WIDTH + 1)'(NUM_ROWS);

  grant_e           last_grant_q, last_grant_d;
  logic             rd_pend_q, rd_pend_d;
  logic             fifo_valid, fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   outstanding;
  logic             rsp_pop, rd_ok, gnt_wr, gnt_rd;

  assign rsp_valid = fifo_valid && !RST;
  assign rsp_pop   = rsp_valid && rsp_ready;

  // Credit counts reads in the buffer plus the one in flight; a pop this cycle frees a slot.
  assign outstanding = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pend_q}
                     - {{CNT_W{1'b0}}, rsp_pop};
  assign rd_ok       = outstanding < (CNT_W + 1)'(RSP_DEPTH);

  always_comb begin
    gnt_wr       = 1'b0;
    gnt_rd       = 1'b0;
    last_grant_d = last_grant_q;
    if (!RST) begin
      if (wr_valid && rd_valid && rd_ok) begin
        if (last_grant_q == GRANT_WR) gnt_rd = 1'b1;
        else                          gnt_wr = 1'b1;
      end else if (wr_valid) begin
        gnt_wr = 1'b1;
      end else if (rd_valid && rd_ok) begin
        gnt_rd = 1'b1;
      end
    end
    if (gnt_wr) last_grant_d = GRANT_WR;
    if (gnt_rd) last_grant_d = GRANT_RD;
    rd_pend_d = gnt_rd;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_pend_q    <= 1'b0;
      last_grant_q <= GRANT_WR;
    end else begin
      rd_pend_q    <= rd_pend_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign wr_ready = gnt_wr;
  assign rd_ready = gnt_rd;
  assign CEB      = gnt_wr || gnt_rd;
  assign WEB      = gnt_wr;
  assign A        = gnt_wr ? wr_addr : (gnt_rd ? rd_addr : '0);
  assign D        = gnt_wr ? wr_data : '0;
  assign M        = gnt_wr ? wr_mask : '0;

  sram_rsp_fifo #(
    .WIDTH (WIDTH)
  ) u_rsp_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (rd_pend_q),
    .push_data (Q),
    .pop       (rsp_pop),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .count     (fifo_count),
    .pop_data  (rsp_data)
  );

  a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
    rd_pend_q |-> (!fifo_full || rsp_pop));

  a_addr_range: assert property (@(posedge CLK) disable iff (RST)
    CEB |-> ({1'b0, A} < ROWS_LIMIT));

endmodule

`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_sram_access_ctrl : directed + random bench with behavioural model |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sram_access_ctrl;

  localparam int W  = 8;
  localparam int NR = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_init;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, A;
  logic [W-1:0]  wr_data, wr_mask, D, M, Q;
  logic          rsp_valid, rsp_ready, CEB, WEB;
  logic [W-1:0]  rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_access_ctrl #(.WIDTH(W), .NUM_ROWS(NR)) dut (
    .CLK(clk), .RST(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .CEB(CEB), .WEB(WEB), .A(A), .D(D), .M(M), .Q(Q)
  );

  // SRAM model: Q registered on reads, garbage after writes.
  logic [W-1:0] mem [NR];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NR; i++) mem[i] <= '0;
    end else if (CEB && WEB) begin
      mem[A] <= (mem[A] & ~M) | (D & M);
      Q      <= W'($urandom);
    end else if (CEB) begin
      Q <= mem[A];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: shadow memory plus queue of responses not yet consumed.
  logic [W-1:0] shadow [NR];
  logic [W-1:0] q_data [$];
  int           q_avail [$];
  int           cyc = 0;
  bit           m_last_rd = 1'b0;
  bit           e_rv, e_pop, e_ew, e_er;

  always @(negedge clk) begin
    if (cyc == 0) for (int i = 0; i < NR; i++) shadow[i] = '0;
    if (rst) begin
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_rd_ready", 32'(rd_ready), 32'd0);
      chk("rst_ceb", 32'(CEB), 32'd0);
      chk("rst_web", 32'(WEB), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      q_data.delete();
      q_avail.delete();
      m_last_rd = 1'b0;
    end else begin
      e_rv  = (q_data.size() != 0) && (q_avail[0] <= cyc);
      e_pop = e_rv && rsp_ready;
      e_ew  = wr_valid;
      e_er  = rd_valid && ((int'(q_data.size()) - int'(e_pop)) < 2);
      if (e_ew && e_er) begin
        if (m_last_rd) e_er = 1'b0;
        else           e_ew = 1'b0;
      end
      chk("wr_ready", 32'(wr_ready), 32'(e_ew));
      chk("rd_ready", 32'(rd_ready), 32'(e_er));
      chk("ceb", 32'(CEB), 32'(e_ew || e_er));
      chk("web", 32'(WEB), 32'(e_ew));
      chk("addr", 32'(A), e_ew ? 32'(wr_addr) : (e_er ? 32'(rd_addr) : 32'd0));
      chk("wdata", 32'(D), e_ew ? 32'(wr_data) : 32'd0);
      chk("wmask", 32'(M), e_ew ? 32'(wr_mask) : 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (e_rv) chk("rsp_data", 32'(rsp_data), 32'(q_data[0]));
      if (e_pop) begin
        void'(q_data.pop_front());
        void'(q_avail.pop_front());
      end
      if (e_ew) begin
        shadow[wr_addr] = (shadow[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        m_last_rd = 1'b0;
      end
      if (e_er) begin
        q_data.push_back(shadow[rd_addr]);
        q_avail.push_back(cyc + 2);
        m_last_rd = 1'b1;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wr_op(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
    int n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    @(negedge clk);
    while (!wr_ready && n < 20) begin @(negedge clk); n++; end
    chk("wr_handshake", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd_expect(input logic [AW-1:0] a, input logic [W-1:0] exp, input string nm);
    int n = 0;
    rd_valid = 1'b1; rd_addr = a;
    @(negedge clk);
    while (!rd_ready && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_hs"}, 32'(rd_ready), 32'd1);
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1"}, 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_data"}, 32'(rsp_data), 32'(exp));
    tick();
  endtask

  function automatic logic [W-1:0] exp_row(input int i);
    return (i == 5) ? 8'hF0 : ((i == 7) ? 8'h3C : 8'hFF);
  endfunction

  initial begin
    int acc, issued, got, last_c;
    bit wacc, racc;
    rst = 1'b1; mem_init = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    wr_addr = '0; wr_data = '0; wr_mask = '0; rd_addr = '0;
    tick();
    mem_init = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // 1: full-mask write then read of the same row on the next cycle
    wr_op(4'd3, 8'hA5, 8'hFF);
    rd_expect(4'd3, 8'hA5, "t1");

    // 2: partial mask over a prefilled row
    for (int i = 0; i < NR; i++) wr_op(AW'(i), 8'hFF, 8'hFF);
    wr_op(4'd5, 8'h00, 8'h0F);
    rd_expect(4'd5, 8'hF0, "t2");

    // 3: both streams held -> alternate starting with the read
    wr_op(4'd0, 8'h00, 8'h00);
    wr_valid = 1'b1; wr_addr = 4'd1; wr_data = 8'h55; wr_mask = 8'h00;
    rd_valid = 1'b1; rd_addr = 4'd2;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t3_rd_grant", 32'(rd_ready), 32'((c % 2) == 0));
      chk("t3_wr_grant", 32'(wr_ready), 32'((c % 2) == 1));
      chk("t3_ceb", 32'(CEB), 32'd1);
      tick();
    end
    idle(4);

    // 4: back-pressure caps outstanding reads at two
    rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 4'd8; acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      racc = rd_ready;
      if (racc) acc++;
      if (c == 5) chk("t4_stalled", 32'(rd_ready), 32'd0);
      tick();
      if (racc) rd_addr = rd_addr + 1'b1;
    end
    chk("t4_accepted", 32'(acc), 32'd2);
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      racc = rd_ready;
      chk("t4_flow_rd", 32'(rd_ready), 32'd1);
      chk("t4_flow_rsp", 32'(rsp_valid), 32'd1);
      if (c < 2) chk("t4_first_data", 32'(rsp_data), 32'hFF);
      tick();
      if (racc) rd_addr = rd_addr + 1'b1;
    end
    idle(4);

    // 5: reset right after a read grant discards it and restores tie priority
    rd_valid = 1'b1; rd_addr = 4'd4;
    @(negedge clk);
    chk("t5_rd_grant", 32'(rd_ready), 32'd1);
    tick();
    rd_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 8'h00; wr_mask = 8'h00;
    rd_valid = 1'b1; rd_addr = 4'd4;
    @(negedge clk);
    chk("t5_tie_rd", 32'(rd_ready), 32'd1);
    chk("t5_tie_wr", 32'(wr_ready), 32'd0);
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    chk("t5_wr_next", 32'(wr_ready), 32'd1);
    tick();
    idle(4);

    // 6: write then immediate read, then a full back-to-back sweep
    wr_op(4'd7, 8'h3C, 8'hFF);
    rd_expect(4'd7, 8'h3C, "t6");
    issued = 0; got = 0; last_c = -1;
    rd_valid = 1'b1; rd_addr = 4'd0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (rd_valid && rd_ready) issued++;
      if (rsp_valid) begin
        chk("t6_sweep_data", 32'(rsp_data), 32'(exp_row(got)));
        got++;
        last_c = c;
      end
      tick();
      rd_valid = (issued < NR);
      rd_addr  = AW'(issued);
    end
    chk("t6_sweep_count", 32'(got), 32'd16);
    chk("t6_sweep_last", 32'(last_c), 32'd17);
    idle(2);

    // Random traffic with occasional resets and response back-pressure
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      wacc = wr_valid && wr_ready;
      racc = rd_valid && rd_ready;
      tick();
      if (!wr_valid || wacc) begin
        wr_valid = 1'($urandom_range(0, 1));
        wr_addr  = AW'($urandom);
        wr_data  = W'($urandom);
        wr_mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
      end
      if (!rd_valid || racc) begin
        rd_valid = 1'($urandom_range(0, 1));
        rd_addr  = AW'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0; rsp_ready = 1'b1;
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
